// File: rtl/alu_control_sequencer_pkg.sv
// alu_control_sequencer_pkg: shared state codes, opcodes and ir field layout for the control sequencer
package cpu_ctrl_pkg;
   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_DONE = 4'd8;
   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;
   // register fields follow the opcode in order ra, rb, rc
   localparam int RA_FIELD = 1;
   localparam int RB_FIELD = 2;
   localparam int RC_FIELD = 3;
   function automatic int field_lsb(input int data_w, input int opcode_w, input int reg_sel_w, input int field);
      return data_w - opcode_w - field * reg_sel_w;
   endfunction
endpackage

// File: rtl/alu_control_sequencer_if.sv
// alu_control_sequencer_if: control/status and DataPath enable bundle between sequencer (master) and DataPath/bench (slave)
//   start, mem_ready, ir          : into the sequencer
//   busy, done, illegal           : sequencer status
//   pc_out .. hi_in               : single-bit DataPath enables
//   reg_in, reg_out, alu_code     : one-hot register enables and ALU select
interface alu_control_sequencer_if #(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 32,
   parameter int OPCODE_W = 5
);
   logic                start, mem_ready;
   logic [DATA_W-1:0]   ir;
   logic                busy, done, illegal;
   logic                pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out;
   logic                ir_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in;
   logic [NUM_REGS-1:0] reg_in, reg_out;
   logic [OPCODE_W-1:0] alu_code;
   modport master (
      input  start, mem_ready, ir,
      output busy, done, illegal, pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out,
             ir_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_in, reg_out, alu_code
   );
   modport slave (
      output start, mem_ready, ir,
      input  busy, done, illegal, pc_out, mar_in, inc_pc, pc_in, mem_read, mdr_in, mdr_out,
             ir_in, y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, reg_in, reg_out, alu_code
   );
endinterface

// File: rtl/alu_control_sequencer_reg_select_decoder.sv
// reg_select_decoder: register index to one-hot enable; indices with no register decode to all zeros
//   i_sel    : register index
//   i_en     : gate for the whole output
//   o_onehot : one-hot register enable
module reg_select_decoder #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4
)(
   input  logic [REG_SEL_W-1:0] i_sel,
   input  logic                 i_en,
   output logic [NUM_REGS-1:0]  o_onehot
);
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
      assign o_onehot[g] = i_en && (i_sel == REG_SEL_W'(g));
   end
endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hard-wired fetch/execute control unit driving the DataPath enables
//   i_clock : rising-edge clock
//   i_clear : asynchronous active-low clear
//   bus     : master side of alu_control_sequencer_if (start/mem_ready/ir in, status and enables out)
module alu_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_REGS  = 16,
   parameter int DATA_W    = 32,
   parameter int OPCODE_W  = 5,
   parameter int REG_SEL_W = 4
)(
   input logic                     i_clock,
   input logic                     i_clear,
   alu_control_sequencer_if.master bus
);
   localparam int RA_LSB = field_lsb(DATA_W, OPCODE_W, REG_SEL_W, RA_FIELD);
   localparam int RB_LSB = field_lsb(DATA_W, OPCODE_W, REG_SEL_W, RB_FIELD);
   localparam int RC_LSB = field_lsb(DATA_W, OPCODE_W, REG_SEL_W, RC_FIELD);
   logic [3:0]           r_state, w_next;
   logic [OPCODE_W-1:0]  r_op, w_op;
   logic [REG_SEL_W-1:0] r_ra, r_rb, r_rc, w_ra, w_rb, w_rc;
   logic                 w_t3, w_legal, w_muldiv, w_unused_ir;
   logic [NUM_REGS-1:0]  w_rb_oh, w_rc_oh;
   // ir is only valid from T3 on: decode live in T3, then run T4..T6 from the copy taken at the end of T3
   assign w_t3   = r_state == S_T3;
   assign w_op   = w_t3 ? bus.ir[DATA_W-1 -: OPCODE_W] : r_op;
   assign w_ra   = w_t3 ? bus.ir[RA_LSB +: REG_SEL_W] : r_ra;
   assign w_rb   = w_t3 ? bus.ir[RB_LSB +: REG_SEL_W] : r_rb;
   assign w_rc   = w_t3 ? bus.ir[RC_LSB +: REG_SEL_W] : r_rc;
   assign w_unused_ir = ^bus.ir[RC_LSB-1:0];
   assign w_muldiv = w_op == OPCODE_W'(OP_MUL) || w_op == OPCODE_W'(OP_DIV);
   assign w_legal  = (w_op inside {OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
                                   OPCODE_W'(OP_OR), OPCODE_W'(OP_MUL), OPCODE_W'(OP_DIV)})
                     && int'(w_ra) < NUM_REGS && int'(w_rb) < NUM_REGS && int'(w_rc) < NUM_REGS;
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE, S_DONE: w_next = bus.start ? S_T0 : S_IDLE;
         S_T0:           w_next = S_T1;
         S_T1:           w_next = bus.mem_ready ? S_T2 : S_T1;
         S_T2:           w_next = S_T3;
         S_T3:           w_next = w_legal ? S_T4 : S_IDLE;
         S_T4:           w_next = S_T5;
         S_T5:           w_next = w_muldiv ? S_T6 : S_DONE;
         S_T6:           w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clock or negedge i_clear) begin
      if (!i_clear) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rc    <= '0;
      end else begin
         r_state <= w_next;
         if (w_t3) begin
            r_op <= w_op;
            r_ra <= w_ra;
            r_rb <= w_rb;
            r_rc <= w_rc;
         end
      end
   end
   assign bus.busy     = r_state != S_IDLE;
   assign bus.done     = r_state == S_DONE;
   assign bus.illegal  = w_t3 && !w_legal;
   assign bus.pc_out   = r_state == S_T0;
   assign bus.mar_in   = r_state == S_T0;
   assign bus.inc_pc   = r_state == S_T0;
   assign bus.z_in     = r_state == S_T0 || r_state == S_T4;
   assign bus.mem_read = r_state == S_T1;
   assign bus.mdr_in   = r_state == S_T1;
   // the incremented PC leaves Z only once the fetch read has completed
   assign bus.pc_in    = r_state == S_T1 && bus.mem_ready;
   assign bus.zlo_out  = (r_state == S_T1 && bus.mem_ready) || r_state == S_T5;
   assign bus.mdr_out  = r_state == S_T2;
   assign bus.ir_in    = r_state == S_T2;
   assign bus.y_in     = w_t3 && w_legal;
   assign bus.alu_code = r_state == S_T4 ? w_op : '0;
   assign bus.lo_in    = r_state == S_T5 && w_muldiv;
   assign bus.zhi_out  = r_state == S_T6;
   assign bus.hi_in    = r_state == S_T6;
   reg_select_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_ra_dec (
      .i_sel(w_ra), .i_en(r_state == S_T5 && !w_muldiv), .o_onehot(bus.reg_in)
   );
   reg_select_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rb_dec (
      .i_sel(w_rb), .i_en(w_t3 && w_legal), .o_onehot(w_rb_oh)
   );
   reg_select_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rc_dec (
      .i_sel(w_rc), .i_en(r_state == S_T4), .o_onehot(w_rc_oh)
   );
   assign bus.reg_out = w_t3 ? w_rb_oh : w_rc_oh;
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed cycle-by-cycle check of the control sequencer enables
module tb_alu_control_sequencer;
   localparam logic [16:0] BUSY = 17'h10000, DN   = 17'h08000, ILL  = 17'h04000, PCO  = 17'h02000;
   localparam logic [16:0] MARI = 17'h01000, INCP = 17'h00800, PCI  = 17'h00400, MRD  = 17'h00200;
   localparam logic [16:0] MDRI = 17'h00100, MDRO = 17'h00080, IRI  = 17'h00040, YI   = 17'h00020;
   localparam logic [16:0] ZI   = 17'h00010, ZLO  = 17'h00008, ZHI  = 17'h00004, LOI  = 17'h00002;
   localparam logic [16:0] HII  = 17'h00001;
   localparam logic [4:0] ADD = 5'b00011, AND_OP = 5'b00101, OR_OP = 5'b00110;
   localparam logic [4:0] MUL = 5'b01111, DIV = 5'b10000, BAD = 5'b11111;
   logic clk = 1'b0;
   logic clear_n = 1'b0;
   logic [16:0] flags;
   int n_cmp = 0;
   int n_bad = 0;
   always #5 clk = ~clk;
   alu_control_sequencer_if bus();
   alu_control_sequencer dut (.i_clock(clk), .i_clear(clear_n), .bus(bus));
   assign flags = {bus.busy, bus.done, bus.illegal, bus.pc_out, bus.mar_in, bus.inc_pc, bus.pc_in,
                   bus.mem_read, bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in,
                   bus.zlo_out, bus.zhi_out, bus.lo_in, bus.hi_in};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      return {op, a, b, c, 15'h0};
   endfunction
   task automatic check_now(input string tag, input logic [16:0] f, input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
      chk($sformatf("%s flags", tag), 32'(flags), 32'(f));
      chk($sformatf("%s reg_in", tag), 32'(bus.reg_in), 32'(rin));
      chk($sformatf("%s reg_out", tag), 32'(bus.reg_out), 32'(rout));
      chk($sformatf("%s alu_code", tag), 32'(bus.alu_code), 32'(alu));
      chk($sformatf("%s one-hot", tag), 32'($countones(bus.reg_out) <= 1), 32'd1);
      chk($sformatf("%s single driver", tag),
          32'($countones({bus.pc_out, bus.mdr_out, bus.zlo_out, bus.zhi_out, |bus.reg_out}) <= 1), 32'd1);
   endtask
   task automatic step(input string tag, input logic [16:0] f, input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
      @(negedge clk);
      check_now(tag, f, rin, rout, alu);
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input string tag, input logic [31:0] ir_v, input int waits);
      bus.mem_ready = 1'b1;
      step($sformatf("%s T0", tag), BUSY | PCO | MARI | INCP | ZI, 0, 0, 0);
      for (int i = 0; i < waits; i++) begin
         bus.mem_ready = 1'b0;
         step($sformatf("%s T1 wait%0d", tag, i), BUSY | MRD | MDRI, 0, 0, 0);
      end
      bus.mem_ready = 1'b1;
      step($sformatf("%s T1", tag), BUSY | MRD | MDRI | ZLO | PCI, 0, 0, 0);
      step($sformatf("%s T2", tag), BUSY | MDRO | IRI, 0, 0, 0);
      bus.ir = ir_v;
   endtask
   // kind: 0 = three-register ALU op, 1 = MUL/DIV, 2 = illegal
   task automatic instr(input string tag, input logic [31:0] ir_v, input int waits, input int kind, input logic hold);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = ir_v[31:27];
      ra = ir_v[26:23];
      rb = ir_v[22:19];
      rc = ir_v[18:15];
      bus.start = hold;
      fetch(tag, ir_v, waits);
      if (kind == 2) begin
         step($sformatf("%s T3", tag), BUSY | ILL, 0, 0, 0);
      end else begin
         step($sformatf("%s T3", tag), BUSY | YI, 0, 16'd1 << rb, 0);
         step($sformatf("%s T4", tag), BUSY | ZI, 0, 16'd1 << rc, op);
         if (kind == 0) begin
            step($sformatf("%s T5", tag), BUSY | ZLO, 16'd1 << ra, 0, 0);
         end else begin
            step($sformatf("%s T5", tag), BUSY | ZLO | LOI, 0, 0, 0);
            step($sformatf("%s T6", tag), BUSY | ZHI | HII, 0, 0, 0);
         end
         step($sformatf("%s DONE", tag), BUSY | DN, 0, 0, 0);
      end
   endtask
   task automatic launch(input string tag);
      bus.start = 1'b1;
      step($sformatf("%s IDLE", tag), 0, 0, 0, 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.mem_ready = 1'b0;
      bus.ir = '0;
      repeat (2) @(posedge clk);
      #1;
      step("in reset", 0, 0, 0, 0);
      clear_n = 1'b1;
      step("idle", 0, 0, 0, 0);
      launch("or");
      instr("or", mk(OR_OP, 4, 3, 7), 0, 0, 1'b0);
      step("or after", 0, 0, 0, 0);
      launch("orw");
      instr("orw", mk(OR_OP, 4, 3, 7), 3, 0, 1'b0);
      step("orw after", 0, 0, 0, 0);
      launch("mul");
      instr("mul", mk(MUL, 0, 2, 4), 0, 1, 1'b0);
      step("mul after", 0, 0, 0, 0);
      launch("div");
      instr("div", mk(DIV, 5, 9, 15), 1, 1, 1'b0);
      step("div after", 0, 0, 0, 0);
      launch("alias");
      instr("alias", mk(ADD, 6, 6, 6), 0, 0, 1'b0);
      step("alias after", 0, 0, 0, 0);
      launch("ill");
      instr("ill", mk(BAD, 1, 2, 3), 0, 2, 1'b0);
      step("ill after0", 0, 0, 0, 0);
      step("ill after1", 0, 0, 0, 0);
      launch("b2b");
      instr("b2b0", mk(ADD, 1, 2, 3), 0, 0, 1'b1);
      instr("b2b1", mk(ADD, 8, 9, 10), 0, 0, 1'b0);
      step("b2b after", 0, 0, 0, 0);
      launch("rst");
      bus.start = 1'b0;
      fetch("rst", mk(AND_OP, 2, 3, 4), 0);
      step("rst T3", BUSY | YI, 0, 16'd1 << 3, 0);
      #2;
      check_now("rst T4", BUSY | ZI, 0, 16'd1 << 4, AND_OP);
      clear_n = 1'b0;
      #1;
      check_now("rst async", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      clear_n = 1'b1;
      step("rst release0", 0, 0, 0, 0);
      step("rst release1", 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
